// File: rtl/jzjpcc_writeback_pkg.sv
// Shared types and helpers for the writeback stage: load funct3 encodings,
// rd_source selector values and access-size decode.
package jzjpcc_writeback_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_funct3_e;

    localparam logic RD_SRC_ALU  = 1'b0;
    localparam logic RD_SRC_LOAD = 1'b1;

    localparam int unsigned SIZE_W = 4;

    // Access size in bytes; 0 marks an encoding that is never a load.
    function automatic logic [SIZE_W-1:0] size_bytes(input logic [2:0] funct3);
        logic [SIZE_W-1:0] size;
        case (funct3)
            F3_LB, F3_LBU: size = SIZE_W'(1);
            F3_LH, F3_LHU: size = SIZE_W'(2);
            F3_LW, F3_LWU: size = SIZE_W'(4);
            F3_LD:         size = SIZE_W'(8);
            default:       size = '0;
        endcase
        return size;
    endfunction

    function automatic logic is_signed_load(input logic [2:0] funct3);
        return !funct3[2];
    endfunction

endpackage

// File: rtl/jzjpcc_load_align.sv
// Combinational load extraction: shifts the raw memory word down to the
// lowest accessed lane, sign/zero-extends it and flags malformed accesses.
module jzjpcc_load_align
    import jzjpcc_writeback_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   memory_out,
    input  logic [XLEN/8-1:0] mem_byte_mask,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   load_data,
    output logic              fault
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(NB + 1);

    logic [OFF_W-1:0]  offset;
    logic [CNT_W-1:0]  popcnt;
    logic [NB-1:0]     run;
    logic [XLEN-1:0]   shifted;
    logic [SIZE_W-1:0] size;
    logic              legal;
    logic              contiguous;
    logic              aligned;
    logic              size_match;

    // Scan downwards so the last hit is the lowest set lane.
    always_comb begin
        offset = '0;
        popcnt = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (mem_byte_mask[i]) begin
                offset = OFF_W'(i);
                popcnt = popcnt + CNT_W'(1);
            end
        end
    end

    // After removing trailing zeros a contiguous mask is 2^k-1.
    assign run        = mem_byte_mask >> offset;
    assign contiguous = ((run & (run + NB'(1))) == '0);

    assign size       = size_bytes(funct3);
    assign size_match = (SIZE_W'(popcnt) == size);
    assign aligned    = ((SIZE_W'(offset) & (size - SIZE_W'(1))) == '0);

    always_comb begin
        legal = 1'b1;
        case (funct3)
            F3_LD, F3_LWU: legal = (XLEN == 64);
            3'b111:        legal = 1'b0;
            default:       legal = 1'b1;
        endcase
    end

    assign fault = (mem_byte_mask == '0) || !legal || !contiguous
                   || !size_match || !aligned;

    assign shifted = memory_out >> {offset, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = XLEN'($signed(shifted[7:0]));
            F3_LH:   load_data = XLEN'($signed(shifted[15:0]));
            F3_LW:   load_data = XLEN'($signed(shifted[31:0]));
            F3_LBU:  load_data = XLEN'(shifted[7:0]);
            F3_LHU:  load_data = XLEN'(shifted[15:0]);
            F3_LWU:  load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/jzjpcc_writeback_unit.sv
// Writeback stage: registers the selected ALU/load result for the register
// file, mirrors it on the forwarding port, counts retirements, flags bad loads.
module jzjpcc_writeback_unit
    import jzjpcc_writeback_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned RETIRE_CNT_W = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    hold,
    input  logic [REG_ADDR_W-1:0]   rd_addr,
    input  logic                    rd_write_enable,
    input  logic                    rd_source,
    input  logic [XLEN-1:0]         memory_out,
    input  logic [XLEN-1:0]         alu_result,
    input  logic [2:0]              funct3,
    input  logic [XLEN/8-1:0]       mem_byte_mask,
    output logic [REG_ADDR_W-1:0]   rf_rd_addr,
    output logic [XLEN-1:0]         rf_rd_data,
    output logic                    rf_write_enable,
    output logic                    fwd_valid,
    output logic [REG_ADDR_W-1:0]   fwd_addr,
    output logic [XLEN-1:0]         fwd_data,
    output logic [RETIRE_CNT_W-1:0] retired_count,
    output logic                    load_fault,
    output logic                    load_fault_sticky
);

    logic [XLEN-1:0] load_data;
    logic            align_fault;
    logic            transfer;
    logic            is_fault;
    logic            next_we;
    logic [XLEN-1:0] next_data;

    jzjpcc_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .memory_out    (memory_out),
        .mem_byte_mask (mem_byte_mask),
        .funct3        (funct3),
        .load_data     (load_data),
        .fault         (align_fault)
    );

    assign in_ready = !hold;
    assign transfer = in_valid && in_ready;
    assign is_fault = (rd_source == RD_SRC_LOAD) && align_fault;

    // A faulting load still retires but writes nothing and carries zero data.
    always_comb begin
        next_data = alu_result;
        if (is_fault) begin
            next_data = '0;
        end else if (rd_source == RD_SRC_LOAD) begin
            next_data = load_data;
        end
    end

    assign next_we = rd_write_enable && (rd_addr != '0) && !is_fault;

    // Write strobe and fault pulse live for exactly one cycle per transfer;
    // hold and idle cycles keep address/data so forwarding still sees them.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_write_enable   <= 1'b0;
            rf_rd_addr        <= '0;
            rf_rd_data        <= '0;
            retired_count     <= '0;
            load_fault        <= 1'b0;
            load_fault_sticky <= 1'b0;
        end else begin
            rf_write_enable <= 1'b0;
            load_fault      <= 1'b0;
            if (transfer) begin
                rf_write_enable <= next_we;
                rf_rd_addr      <= rd_addr;
                rf_rd_data      <= next_data;
                load_fault      <= is_fault;
                retired_count   <= retired_count + RETIRE_CNT_W'(1);
                if (is_fault) begin
                    load_fault_sticky <= 1'b1;
                end
            end
        end
    end

    assign fwd_valid = rf_write_enable;
    assign fwd_addr  = rf_rd_addr;
    assign fwd_data  = rf_rd_data;

endmodule

// File: tb/tb_jzjpcc_writeback_unit.sv
// Self-checking bench for jzjpcc_writeback_unit: directed vector tables for
// the XLEN=32 and XLEN=64 builds, hold/reset sequences, and random traffic.
module tb_jzjpcc_writeback_unit;

    logic        clock;
    logic        reset;
    logic        in_valid, hold, rd_write_enable, rd_source;
    logic [4:0]  rd_addr;
    logic [31:0] memory_out, alu_result;
    logic [2:0]  funct3;
    logic [3:0]  mem_byte_mask;
    logic        in_ready, rf_write_enable, fwd_valid, load_fault, load_fault_sticky;
    logic [4:0]  rf_rd_addr, fwd_addr;
    logic [31:0] rf_rd_data, fwd_data;
    logic [63:0] retired_count;

    logic        w_in_valid, w_hold, w_we_in, w_src;
    logic [4:0]  w_rd_addr;
    logic [63:0] w_mem, w_alu;
    logic [2:0]  w_f3;
    logic [7:0]  w_mask;
    logic        w_in_ready, w_we, w_fwd_valid, w_fault, w_sticky;
    logic [4:0]  w_addr, w_fwd_addr;
    logic [63:0] w_data, w_fwd_data, w_count;

    jzjpcc_writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .RETIRE_CNT_W(64)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .hold(hold), .rd_addr(rd_addr), .rd_write_enable(rd_write_enable),
        .rd_source(rd_source), .memory_out(memory_out), .alu_result(alu_result),
        .funct3(funct3), .mem_byte_mask(mem_byte_mask), .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data), .rf_write_enable(rf_write_enable),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retired_count(retired_count), .load_fault(load_fault),
        .load_fault_sticky(load_fault_sticky)
    );

    jzjpcc_writeback_unit #(.XLEN(64), .REG_ADDR_W(5), .RETIRE_CNT_W(64)) u_dut64 (
        .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .hold(w_hold), .rd_addr(w_rd_addr), .rd_write_enable(w_we_in),
        .rd_source(w_src), .memory_out(w_mem), .alu_result(w_alu),
        .funct3(w_f3), .mem_byte_mask(w_mask), .rf_rd_addr(w_addr),
        .rf_rd_data(w_data), .rf_write_enable(w_we),
        .fwd_valid(w_fwd_valid), .fwd_addr(w_fwd_addr), .fwd_data(w_fwd_data),
        .retired_count(w_count), .load_fault(w_fault),
        .load_fault_sticky(w_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference state for the XLEN=32 instance
    logic        m_we, m_fault, m_sticky;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [63:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-level load semantics: which lanes, what size, what extension.
    function automatic void model_load(input int xlen, input logic [63:0] mem,
                                       input logic [7:0] mask, input logic [2:0] f3,
                                       output logic [63:0] val, output logic flt);
        int nb, sz, lo, cnt;
        nb = xlen / 8;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            3'd6:       sz = (xlen == 64) ? 4 : 0;
            3'd3:       sz = (xlen == 64) ? 8 : 0;
            default:    sz = 0;
        endcase
        lo = -1;
        cnt = 0;
        for (int i = 0; i < nb; i++) begin
            if (mask[i]) begin
                if (lo < 0) lo = i;
                cnt++;
            end
        end
        flt = (sz == 0) || (cnt == 0) || (cnt != sz);
        if (!flt) begin
            if ((lo % sz) != 0) flt = 1'b1;
            for (int i = 0; i < nb; i++)
                if (mask[i] && i >= lo + sz) flt = 1'b1;
        end
        val = '0;
        if (!flt) begin
            for (int b = 0; b < sz; b++) val[8*b +: 8] = mem[8*(lo+b) +: 8];
            if (f3 < 3'd4 && sz < 8 && val[8*sz-1])
                for (int k = 8*sz; k < 64; k++) val[k] = 1'b1;
        end
        if (xlen == 32) val[63:32] = '0;
    endfunction

    task automatic model_step();
        logic [63:0] v;
        logic f;
        if (reset) begin
            m_we = 0; m_fault = 0; m_sticky = 0; m_addr = '0; m_data = '0; m_cnt = '0;
        end else if (hold || !in_valid) begin
            m_we = 0; m_fault = 0;
        end else begin
            model_load(32, {32'h0, memory_out}, {4'h0, mem_byte_mask}, funct3, v, f);
            f = f && rd_source;
            m_addr   = rd_addr;
            m_data   = f ? 32'h0 : (rd_source ? v[31:0] : alu_result);
            m_we     = rd_write_enable && (rd_addr != 5'd0) && !f;
            m_fault  = f;
            m_sticky = m_sticky | f;
            m_cnt    = m_cnt + 64'd1;
        end
    endtask

    // One clock: check handshake, advance model, compare registered outputs.
    task automatic tick();
        #1;
        check("in_ready", 64'(in_ready), 64'(!hold));
        model_step();
        @(posedge clock);
        #1;
        check("rf_write_enable", 64'(rf_write_enable), 64'(m_we));
        check("rf_rd_addr", 64'(rf_rd_addr), 64'(m_addr));
        check("rf_rd_data", 64'(rf_rd_data), 64'(m_data));
        check("load_fault", 64'(load_fault), 64'(m_fault));
        check("load_fault_sticky", 64'(load_fault_sticky), 64'(m_sticky));
        check("retired_count", retired_count, m_cnt);
        check("fwd_valid", 64'(fwd_valid), 64'(m_we));
        check("fwd_addr", 64'(fwd_addr), 64'(m_addr));
        check("fwd_data", 64'(fwd_data), 64'(m_data));
    endtask

    typedef struct {
        logic        valid;
        logic [4:0]  addr;
        logic        we;
        logic        src;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [2:0]  f3;
        logic [3:0]  mask;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [7:0]  mask;
        logic        exp_we;
        logic [63:0] exp_data;
        logic        exp_fault;
    } vec64_t;

    function automatic vec_t mk(input logic valid, input logic [4:0] addr, input logic we,
                                input logic src, input logic [31:0] mem, input logic [31:0] alu,
                                input logic [2:0] f3, input logic [3:0] mask,
                                input logic exp_we, input logic [31:0] exp_data, input logic exp_fault);
        vec_t v;
        v.valid = valid; v.addr = addr; v.we = we; v.src = src; v.mem = mem; v.alu = alu;
        v.f3 = f3; v.mask = mask; v.exp_we = exp_we; v.exp_data = exp_data; v.exp_fault = exp_fault;
        return v;
    endfunction

    function automatic vec64_t mk64(input logic [2:0] f3, input logic [7:0] mask,
                                    input logic exp_we, input logic [63:0] exp_data,
                                    input logic exp_fault);
        vec64_t v;
        v.f3 = f3; v.mask = mask; v.exp_we = exp_we; v.exp_data = exp_data; v.exp_fault = exp_fault;
        return v;
    endfunction

    vec_t   tbl[16];
    vec64_t tbl64[5];

    initial begin
        logic [31:0] saved_data;
        logic [63:0] saved_cnt;
        localparam logic [31:0] M = 32'h80FF_7F01;

        tbl[0]  = mk(1, 5'd5, 1, 0, M, 32'h0000_1234, 3'd0, 4'b0000, 1, 32'h0000_1234, 0);
        tbl[1]  = mk(1, 5'd3, 1, 1, M, 32'h0,         3'd0, 4'b0100, 1, 32'hFFFF_FFFF, 0);
        tbl[2]  = mk(1, 5'd3, 1, 1, M, 32'h0,         3'd0, 4'b0010, 1, 32'h0000_007F, 0);
        tbl[3]  = mk(1, 5'd3, 1, 1, M, 32'h0,         3'd5, 4'b1100, 1, 32'h0000_80FF, 0);
        tbl[4]  = mk(1, 5'd6, 1, 1, M, 32'h0,         3'd1, 4'b0110, 0, 32'h0,         1);
        tbl[5]  = mk(1, 5'd0, 1, 0, M, 32'hDEAD_BEEF, 3'd0, 4'b0000, 0, 32'hDEAD_BEEF, 0);
        tbl[6]  = mk(1, 5'd9, 1, 1, M, 32'h0,         3'd2, 4'b1111, 1, 32'h80FF_7F01, 0);
        tbl[7]  = mk(1, 5'd9, 1, 1, M, 32'h0,         3'd1, 4'b0011, 1, 32'h0000_7F01, 0);
        tbl[8]  = mk(1, 5'd9, 1, 1, M, 32'h0,         3'd1, 4'b1100, 1, 32'hFFFF_80FF, 0);
        tbl[9]  = mk(1, 5'd9, 1, 1, M, 32'h0,         3'd0, 4'b0000, 0, 32'h0,         1);
        tbl[10] = mk(1, 5'd9, 1, 1, M, 32'h0,         3'd3, 4'b1111, 0, 32'h0,         1);
        tbl[11] = mk(1, 5'd9, 1, 1, M, 32'h0,         3'd7, 4'b0001, 0, 32'h0,         1);
        tbl[12] = mk(1, 5'd9, 1, 1, M, 32'h0,         3'd0, 4'b0011, 0, 32'h0,         1);
        tbl[13] = mk(1, 5'd9, 1, 0, M, 32'h0000_0055, 3'd7, 4'b0101, 1, 32'h0000_0055, 0);
        tbl[14] = mk(1, 5'd4, 0, 0, M, 32'h0000_0077, 3'd0, 4'b0000, 0, 32'h0000_0077, 0);
        tbl[15] = mk(0, 5'd8, 1, 0, M, 32'h0000_0099, 3'd0, 4'b0000, 0, 32'h0000_0077, 0);

        tbl64[0] = mk64(3'd3, 8'hFF, 1, 64'h8123_4567_89AB_CDEF, 0);
        tbl64[1] = mk64(3'd6, 8'hF0, 1, 64'h0000_0000_8123_4567, 0);
        tbl64[2] = mk64(3'd2, 8'hF0, 1, 64'hFFFF_FFFF_8123_4567, 0);
        tbl64[3] = mk64(3'd1, 8'h0C, 1, 64'hFFFF_FFFF_FFFF_89AB, 0);
        tbl64[4] = mk64(3'd3, 8'h0F, 0, 64'h0,                   1);

        reset = 1; in_valid = 0; hold = 0; rd_addr = '0; rd_write_enable = 0;
        rd_source = 0; memory_out = '0; alu_result = '0; funct3 = '0; mem_byte_mask = '0;
        w_in_valid = 0; w_hold = 0; w_rd_addr = 5'd10; w_we_in = 1; w_src = 1;
        w_mem = 64'h8123_4567_89AB_CDEF; w_alu = '0; w_f3 = '0; w_mask = '0;
        tick();
        tick();
        reset = 0;

        // XLEN=64 build: the 32-bit instance idles meanwhile
        foreach (tbl64[i]) begin
            w_in_valid = 1; w_f3 = tbl64[i].f3; w_mask = tbl64[i].mask;
            tick();
            check("w64_we", 64'(w_we), 64'(tbl64[i].exp_we));
            check("w64_data", w_data, tbl64[i].exp_data);
            check("w64_addr", 64'(w_addr), 64'd10);
            check("w64_fault", 64'(w_fault), 64'(tbl64[i].exp_fault));
            check("w64_fwd", w_fwd_data, tbl64[i].exp_data);
            check("w64_fwd_valid", 64'(w_fwd_valid), 64'(tbl64[i].exp_we));
            check("w64_fwd_addr", 64'(w_fwd_addr), 64'd10);
            check("w64_sticky", 64'(w_sticky), 64'(i >= 4));
            check("w64_count", w_count, 64'(i + 1));
            check("w64_in_ready", 64'(w_in_ready), 64'd1);
        end
        w_in_valid = 0;

        // Directed table on the XLEN=32 instance
        foreach (tbl[i]) begin
            in_valid = tbl[i].valid; rd_addr = tbl[i].addr; rd_write_enable = tbl[i].we;
            rd_source = tbl[i].src; memory_out = tbl[i].mem; alu_result = tbl[i].alu;
            funct3 = tbl[i].f3; mem_byte_mask = tbl[i].mask;
            tick();
            check("tbl_we", 64'(rf_write_enable), 64'(tbl[i].exp_we));
            check("tbl_data", 64'(rf_rd_data), 64'(tbl[i].exp_data));
            check("tbl_fault", 64'(load_fault), 64'(tbl[i].exp_fault));
        end
        check("sticky_after_table", 64'(load_fault_sticky), 64'd1);

        // Hold: the x7 entry stays visible, no rewrite, no retirement
        in_valid = 1; rd_addr = 5'd7; rd_write_enable = 1; rd_source = 0; alu_result = 32'hA5A5_0007;
        tick();
        check("hold_first_we", 64'(rf_write_enable), 64'd1);
        saved_data = m_data;
        saved_cnt  = m_cnt;
        hold = 1; rd_addr = 5'd8; alu_result = 32'h0000_0008;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_we", 64'(rf_write_enable), 64'd0);
            check("hold_addr", 64'(rf_rd_addr), 64'd7);
            check("hold_data", 64'(rf_rd_data), 64'(saved_data));
            check("hold_count", retired_count, saved_cnt);
        end
        hold = 0;
        tick();
        check("release_addr", 64'(rf_rd_addr), 64'd8);
        check("release_we", 64'(rf_write_enable), 64'd1);
        check("release_count", retired_count, saved_cnt + 64'd1);

        // Reset on a transfer cycle drops the instruction
        reset = 1; rd_addr = 5'd11; alu_result = 32'h1111_2222;
        tick();
        reset = 0;
        check("reset_count", retired_count, 64'd0);
        check("reset_data", 64'(rf_rd_data), 64'd0);
        check("reset_we", 64'(rf_write_enable), 64'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            int sz, lo;
            reset           = ($urandom_range(49, 0) == 0);
            in_valid        = ($urandom_range(3, 0) != 0);
            hold            = ($urandom_range(4, 0) == 0);
            rd_addr         = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
            rd_write_enable = ($urandom_range(4, 0) != 0);
            rd_source       = 1'($urandom_range(1, 0));
            memory_out      = $urandom;
            alu_result      = $urandom;
            funct3          = 3'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1) begin
                sz = (funct3[1:0] == 2'd0) ? 1 : (funct3[1:0] == 2'd1) ? 2 : 4;
                lo = sz * int'($urandom_range(4 / sz - 1, 0));
                mem_byte_mask = 4'(((1 << sz) - 1) << lo);
            end else begin
                mem_byte_mask = 4'($urandom_range(15, 0));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jzjpcc_writeback_unit.md
Name: jzjpcc_writeback_unit

Overview:
Parametrised next-generation writeback stage. It takes the memory-stage bundle, extracts, aligns and sign/zero-extends the load data from funct3 and the byte mask, and selects ALU or load data. Results are registered for one cycle before reaching the register file, with a hold/valid handshake. It also provides a forwarding port, a retired-instruction counter and load-fault detection. Sits between the memory stage and the register file.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_ADDR_W, 5, register address width.
RETIRE_CNT_W, 64, width of the retired-instruction counter.

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  memory stage presents a valid instruction
in_ready  out  1  unit can accept this cycle
hold  in  1  hazard unit freezes the output register
rd_addr  in  REG_ADDR_W  destination register
rd_write_enable  in  1  instruction writes rd
rd_source  in  1  0 = alu_result, 1 = load data
memory_out  in  XLEN  raw aligned memory word
alu_result  in  XLEN  ALU result
funct3  in  3  load type
mem_byte_mask  in  XLEN/8  byte lanes accessed
rf_rd_addr  out  REG_ADDR_W  register file write address
rf_rd_data  out  XLEN  register file write data
rf_write_enable  out  1  register file write strobe
fwd_valid  out  1  forwarding entry valid; equals rf_write_enable
fwd_addr  out  REG_ADDR_W  equals rf_rd_addr
fwd_data  out  XLEN  equals rf_rd_data
retired_count  out  RETIRE_CNT_W  instructions retired
load_fault  out  1  one-cycle pulse on a faulting load
load_fault_sticky  out  1  set on any fault; cleared only by reset

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-high.
- Reset values: rf_write_enable=0, rf_rd_addr=0, rf_rd_data=0, retired_count=0, load_fault=0, load_fault_sticky=0. The internal output-valid flag is cleared.
- Handshake: in_ready = !hold. A transfer happens when in_valid && in_ready.
- Latency: an instruction accepted at edge N drives the rf_* outputs during cycle N+1.
- hold=1: output registers keep their values, but rf_write_enable is forced to 0 while hold is high so no duplicate writes occur. The held entry is not re-written after hold drops. Forwarding outputs still show the held entry, with fwd_valid also 0.
- No transfer and no hold: rf_write_enable=0 on the next cycle; data and address registers keep their values.
- x0 rule: rd_addr==0 never produces rf_write_enable=1.
- Load extraction (rd_source=1):
  - offset = index of the lowest set bit of mem_byte_mask.
  - Shift memory_out right by 8*offset.
  - funct3 000 LB: sign-extend 8 bits.
  - funct3 001 LH: sign-extend 16 bits.
  - funct3 010 LW: sign-extend 32 bits; full word when XLEN=32.
  - funct3 011 LD: XLEN=64 only.
  - funct3 100 LBU, 101 LHU, 110 LWU (XLEN=64 only): zero-extend.
- Load fault: the instruction is transferred with rd_source=1 and any of these holds:
  - The mask is not contiguous.
  - The mask popcount does not match the funct3 size.
  - The offset is not aligned to the access size.
  - funct3 is illegal for XLEN (011/110 at XLEN=32, or 111).
  - The mask is zero.
- On a load fault: write suppressed, rf_rd_data=0, load_fault pulses one cycle, load_fault_sticky set.
- rd_source=0: mask and funct3 are ignored, and no fault is raised.
- retired_count increments by 1 on each transfer, including faulting, non-writing and x0 instructions. It wraps modulo 2^RETIRE_CNT_W.
- reset asserted alongside a transfer: reset wins and the instruction is dropped.

Decomposition:
- Package jzjpcc_writeback_pkg holds:
  - load funct3 enum (LB, LH, LW, LD, LBU, LHU, LWU);
  - the rd_source constants;
  - function size_bytes(funct3).
- One combinational sub-module, jzjpcc_load_align. Inputs: memory_out, mem_byte_mask, funct3. Outputs: aligned data and fault. The top level holds the registers, handshake and counter.

Test Plan:
1. ALU write: rd_addr=5, rd_source=0, alu_result=0x0000_1234, in_valid=1 -> next cycle rf_write_enable=1, rf_rd_addr=5, rf_rd_data=0x0000_1234, retired_count=1.
2. LB sign-extend: memory_out=0x80FF_7F01, mask=0b0100, funct3=000 -> rf_rd_data=0xFFFF_FFFF. Same with mask=0b0010 -> 0x0000_007F. LHU with mask=0b1100 -> 0x0000_80FF.
3. Misaligned LH: mask=0b0110, funct3=001 -> rf_write_enable=0, load_fault pulses once, load_fault_sticky=1 held until reset, retired_count increments.
4. x0 write: rd_addr=0, rd_write_enable=1, alu_result=0xDEAD_BEEF -> rf_write_enable=0, retired_count increments.
5. Hold: accept a write to x7, then hold=1 for 3 cycles with in_valid=1 -> in_ready=0, rf_write_enable=0, outputs stable, retired_count unchanged. Release hold -> next instruction accepted.
6. Reset mid-stream: assert reset on a transfer cycle -> next cycle all outputs 0 and retired_count=0. XLEN=64 build: LD with mask=0xFF returns the full 64-bit word; LWU with mask=0xF0 returns the zero-extended upper word.
